mmio_vector_bank: RTL and testbench
===================================

Name: mmio_vector_bank

Overview:
- Fabric-side endpoint for the HPS-exported Avalon-MM masters (data_in, data_control, data_out).
- Holds a parametrised multi-channel input bank and output bank, plus a control/status register file.
- Runs a sequencer that streams N input vectors to a compute core and collects N result vectors into the output bank.
- Generalises the fixed 32-bit/8-bit-address single-channel interface to NUM_CH channels with a configurable data width and depth, and adds start/done/abort handshaking.

Parameters:
- DATA_W, 32, word width per channel.
- ADDR_W, 8, width of the in/out word address; the upper CH_W bits select the channel, the lower IDX_W bits select the index.
- NUM_CH, 2, channel count (power of two, ≥1). CH_W = clog2(NUM_CH), minimum 0. IDX_W = ADDR_W−CH_W. DEPTH = 2^IDX_W.
- LEN_W, ADDR_W+1, width of the LEN register. It must hold DEPTH.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- in_write  in  1  input-bank write strobe.
- in_address  in  ADDR_W  {channel, index}.
- in_writedata  in  DATA_W  input word.
- ctrl_address  in  8  register word address.
- ctrl_read  in  1  register read strobe.
- ctrl_write  in  1  register write strobe.
- ctrl_writedata  in  32  register write data.
- ctrl_readdata  out  32  register read data, 1-cycle latency.
- out_address  in  ADDR_W  {channel, index}.
- out_readdata  out  DATA_W  output-bank word, 1-cycle latency.
- src_valid  out  1  input vector valid to the compute core.
- src_ready  in  1  core accepts the vector.
- src_data  out  NUM_CH*DATA_W  vector at issue index; channel c occupies bits [c*DATA_W +: DATA_W].
- snk_valid  in  1  result vector valid from the core.
- snk_ready  out  1  bank accepts the result.
- snk_data  in  NUM_CH*DATA_W  result vector.

Behaviour:
- Reset: all outputs 0. FSM in IDLE. Counters cleared. LEN=0. STATUS=0. Bank contents undefined (not reset).
- Registers (word addresses):
  - 0 CTRL, write-only: bit0 start, bit1 abort. Both are single-cycle pulses; reads return 0.
  - 1 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 err (W1C).
  - 2 LEN, RW.
  - 3 ID, RO: {8'hA5, NUM_CH[7:0], DEPTH[15:0]}.
  - Unmapped addresses read 0; writes to them are ignored.
- FSM states IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start: clears issue_cnt, res_cnt and done. If LEN=0, goes IDLE→DONE directly.
  - RUN: src_valid=1; src_data comes from a registered read of the input bank at issue_cnt, so it is valid in the same cycle src_valid rises. A transfer occurs when src_valid&src_ready; issue_cnt then increments and the next word is prefetched with no bubble. When issue_cnt reaches LEN, the FSM goes to DRAIN.
  - snk_ready=1 in RUN and DRAIN, 0 otherwise. Each snk_valid&snk_ready writes all channels at index res_cnt, then res_cnt increments.
  - The FSM goes to DONE when res_cnt reaches LEN. This can happen from RUN, because results may overtake the issue count.
  - DONE: sets done=1, then goes to IDLE the next cycle.
- busy=1 in RUN and DRAIN.
- Abort in RUN or DRAIN: returns to IDLE on the next edge. done is not set, src_valid drops, and partial results remain in the bank.
- Start while busy: ignored, err set.
- Start and abort in the same write: abort wins.
- in_write while busy: dropped, err set.
- LEN writes > DEPTH are saturated to DEPTH.
- A LEN write while busy is accepted into the register but does not affect the current run; the run length is latched at start.
- Host reads of the output bank during a run return the current contents; no interlock.
- Channel field ≥ NUM_CH cannot occur (NUM_CH is a power of two).
- A W1C write in the same cycle as a hardware set: the set wins.
- An asynchronous reset mid-run returns to IDLE immediately. Outputs are 0 while reset is held.

Optional Feature:
MMIO_VECTOR_BANK_PERF_CNT_EN
- Defined: register 4 CYCLES (RO, 32-bit) counts cycles spent in RUN or DRAIN. It clears on start and holds after DONE or abort. It saturates at 32'hFFFFFFFF.
- Undefined: address 4 reads 0; no counter logic is instantiated.

Test Plan:
1. NUM_CH=2. Write ch0[i]=i and ch1[i]=100+i for i=0..3, LEN=4, start. The core echoes each vector +1 with src_ready=1 → four src beats in consecutive cycles. out[ch0,0..3]=1..4, out[ch1,0..3]=101..104. STATUS=0x2 two cycles after the last result. With PERF_CNT_EN, CYCLES=5±1.
2. LEN=8, src_ready toggling 1/0 every cycle, results delayed 3 cycles → exactly 8 src beats with no duplicated or skipped index. done=1 only after the 8th result.
3. Start while busy, and an in_write while busy → STATUS=0x5 (busy|err) mid-run; the input bank is unchanged. Writing 0x4 to STATUS clears err.
4. LEN=0, start → done=1 within 2 cycles, src_valid never asserted.
5. LEN=6, abort after 2 results → busy=0 next cycle, done=0, out indices 0..1 updated, 2..5 unchanged.
6. Assert reset_reset_n=0 mid-RUN → src_valid=0, snk_ready=0, STATUS=0 asynchronously. After release, a new start runs normally.

Source files
------------

// File: rtl/mmio_vector_bank.sv
// mmio_vector_bank: fabric-side endpoint for the HPS Avalon-MM masters.
// Holds a NUM_CH-channel input bank and output bank plus a control/status
// register file, and sequences LEN input vectors to a compute core while
// collecting LEN result vectors back into the output bank.
// Optional feature macro: MMIO_VECTOR_BANK_PERF_CNT_EN adds the CYCLES
// counter at register word address 4 (reads 0 when the macro is undefined).
module mmio_vector_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int NUM_CH = 2,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic                     in_write,
    input  logic [ADDR_W-1:0]        in_address,
    input  logic [DATA_W-1:0]        in_writedata,
    input  logic [7:0]               ctrl_address,
    input  logic                     ctrl_read,
    input  logic                     ctrl_write,
    input  logic [31:0]              ctrl_writedata,
    output logic [31:0]              ctrl_readdata,
    input  logic [ADDR_W-1:0]        out_address,
    output logic [DATA_W-1:0]        out_readdata,
    output logic                     src_valid,
    input  logic                     src_ready,
    output logic [NUM_CH*DATA_W-1:0] src_data,
    input  logic                     snk_valid,
    output logic                     snk_ready,
    input  logic [NUM_CH*DATA_W-1:0] snk_data
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
    localparam int CH_IW = (CH_W > 0) ? CH_W : 1;
    localparam int IDX_W = ADDR_W - CH_W;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [31:0]      ID_VAL    = {8'hA5, 8'(NUM_CH), 16'(DEPTH)};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bank storage (never reset)
    logic [DATA_W-1:0] in_mem  [NUM_CH][DEPTH];
    logic [DATA_W-1:0] out_mem [NUM_CH][DEPTH];

    state_t                  state_r, state_s;
    logic [LEN_W-1:0]        len_r, run_len_r, issue_cnt_r, res_cnt_r;
    logic [LEN_W-1:0]        issue_nxt_s, res_nxt_s;
    logic                    done_r, err_r;
    logic                    src_valid_r, snk_ready_r, src_valid_s, snk_ready_s;
    logic [NUM_CH*DATA_W-1:0] src_data_r;
    logic [31:0]             ctrl_readdata_r, rd_mux_s;
    logic [DATA_W-1:0]       out_readdata_r;

    logic                    busy_s, ctrl_reg_wr_s, stat_wr_s, len_wr_s;
    logic                    start_req_s, abort_s, start_go_s, set_err_s;
    logic                    src_fire_s, snk_fire_s;
    logic [IDX_W-1:0]        rd_idx_s, in_idx_s, out_idx_s;
    logic [CH_IW-1:0]        in_ch_s, out_ch_s;

`ifdef MMIO_VECTOR_BANK_PERF_CNT_EN
    logic [31:0]             cycles_r;
`endif

    assign in_ch_s   = CH_IW'(in_address >> IDX_W);
    assign in_idx_s  = in_address[IDX_W-1:0];
    assign out_ch_s  = CH_IW'(out_address >> IDX_W);
    assign out_idx_s = out_address[IDX_W-1:0];

    // Host command decode and handshake qualification
    always_comb begin
        busy_s        = (state_r == ST_RUN) || (state_r == ST_DRAIN);
        ctrl_reg_wr_s = ctrl_write && (ctrl_address == 8'd0);
        stat_wr_s     = ctrl_write && (ctrl_address == 8'd1);
        len_wr_s      = ctrl_write && (ctrl_address == 8'd2);
        abort_s       = ctrl_reg_wr_s && ctrl_writedata[1] && busy_s;
        // abort in the same write suppresses start entirely
        start_req_s   = ctrl_reg_wr_s && ctrl_writedata[0] && !ctrl_writedata[1];
        start_go_s    = start_req_s && (state_r == ST_IDLE);
        set_err_s     = (start_req_s && busy_s) || (in_write && busy_s);
        src_fire_s    = src_valid_r && src_ready;
        snk_fire_s    = snk_ready_r && snk_valid;
        issue_nxt_s   = issue_cnt_r + (src_fire_s ? LEN_W'(1) : LEN_W'(0));
        res_nxt_s     = res_cnt_r + (snk_fire_s ? LEN_W'(1) : LEN_W'(0));
        // prefetch index for the word presented next cycle (no bubble after a beat);
        // a bank write coincident with start is not forwarded
        if (start_go_s) begin
            rd_idx_s = {IDX_W{1'b0}};
        end else begin
            rd_idx_s = issue_cnt_r[IDX_W-1:0] + (src_fire_s ? IDX_W'(1) : IDX_W'(0));
        end
    end

    // FSM state register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; results may complete the run before issue does
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_go_s) begin
                    state_s = (len_r == {LEN_W{1'b0}}) ? ST_DONE : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    state_s = ST_IDLE;
                end else if (res_nxt_s == run_len_r) begin
                    state_s = ST_DONE;
                end else if (issue_nxt_s == run_len_r) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (abort_s) begin
                    state_s = ST_IDLE;
                end else if (res_nxt_s == run_len_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output decode from the next state, so the registered outputs track the state
    always_comb begin
        src_valid_s = 1'b0;
        snk_ready_s = 1'b0;
        case (state_s)
            ST_RUN: begin
                src_valid_s = 1'b1;
                snk_ready_s = 1'b1;
            end
            ST_DRAIN: snk_ready_s = 1'b1;
            default: begin
                src_valid_s = 1'b0;
                snk_ready_s = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs and prefetched source vector
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            src_valid_r <= 1'b0;
            snk_ready_r <= 1'b0;
            src_data_r  <= {(NUM_CH*DATA_W){1'b0}};
        end else begin
            src_valid_r <= src_valid_s;
            snk_ready_r <= snk_ready_s;
            for (int c = 0; c < NUM_CH; c++) begin
                src_data_r[c*DATA_W +: DATA_W] <= in_mem[c][rd_idx_s];
            end
        end
    end

    // Issue/result counters and run length latched at start
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            issue_cnt_r <= {LEN_W{1'b0}};
            res_cnt_r   <= {LEN_W{1'b0}};
            run_len_r   <= {LEN_W{1'b0}};
        end else if (start_go_s) begin
            issue_cnt_r <= {LEN_W{1'b0}};
            res_cnt_r   <= {LEN_W{1'b0}};
            run_len_r   <= len_r;
        end else begin
            issue_cnt_r <= issue_nxt_s;
            res_cnt_r   <= res_nxt_s;
        end
    end

    // Register file: LEN with saturation, sticky done/err where a set beats W1C
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            len_r  <= {LEN_W{1'b0}};
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            if (len_wr_s) begin
                len_r <= (ctrl_writedata > 32'(DEPTH)) ? DEPTH_LEN : LEN_W'(ctrl_writedata);
            end
            if (start_go_s) begin
                done_r <= 1'b0;
            end else if (state_r == ST_DONE) begin
                done_r <= 1'b1;
            end else if (stat_wr_s && ctrl_writedata[1]) begin
                done_r <= 1'b0;
            end
            if (set_err_s) begin
                err_r <= 1'b1;
            end else if (stat_wr_s && ctrl_writedata[2]) begin
                err_r <= 1'b0;
            end
        end
    end

`ifdef MMIO_VECTOR_BANK_PERF_CNT_EN
    // Saturating count of cycles spent in RUN or DRAIN, cleared on start
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cycles_r <= 32'd0;
        end else if (start_go_s) begin
            cycles_r <= 32'd0;
        end else if (busy_s && (cycles_r != 32'hFFFF_FFFF)) begin
            cycles_r <= cycles_r + 32'd1;
        end
    end
`endif

    // Register read multiplexer; CTRL and unmapped words read as zero
    always_comb begin
        rd_mux_s = 32'd0;
        case (ctrl_address)
            8'd1:    rd_mux_s = {29'd0, err_r, done_r, busy_s};
            8'd2:    rd_mux_s = 32'(len_r);
            8'd3:    rd_mux_s = ID_VAL;
`ifdef MMIO_VECTOR_BANK_PERF_CNT_EN
            8'd4:    rd_mux_s = cycles_r;
`endif
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Registered host read data for both the register file and the output bank
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ctrl_readdata_r <= 32'd0;
            out_readdata_r  <= {DATA_W{1'b0}};
        end else begin
            ctrl_readdata_r <= ctrl_read ? rd_mux_s : 32'd0;
            out_readdata_r  <= out_mem[out_ch_s][out_idx_s];
        end
    end

    // Input bank write port; host writes are dropped while a run is active
    always_ff @(posedge clk_clk) begin
        if (in_write && !busy_s) begin
            in_mem[in_ch_s][in_idx_s] <= in_writedata;
        end
    end

    // Output bank write port; one accepted result fills every channel at res_cnt
    always_ff @(posedge clk_clk) begin
        if (snk_fire_s) begin
            for (int c = 0; c < NUM_CH; c++) begin
                out_mem[c][res_cnt_r[IDX_W-1:0]] <= snk_data[c*DATA_W +: DATA_W];
            end
        end
    end

    assign src_valid     = src_valid_r;
    assign snk_ready     = snk_ready_r;
    assign src_data      = src_data_r;
    assign ctrl_readdata = ctrl_readdata_r;
    assign out_readdata  = out_readdata_r;

endmodule

// File: tb/tb_mmio_vector_bank.sv
// Scoreboard bench for mmio_vector_bank (default parameters: 2 channels,
// 32-bit words, depth 128). Optional macro MMIO_VECTOR_BANK_PERF_CNT_EN
// switches the expectation for register 4.
module tb_mmio_vector_bank;
    localparam int NCH = 2;
    localparam int DEP = 128;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        in_write = 1'b0;
    logic [7:0]  in_address = 8'd0;
    logic [31:0] in_writedata = 32'd0;
    logic [7:0]  ctrl_address = 8'd0;
    logic        ctrl_read = 1'b0;
    logic        ctrl_write = 1'b0;
    logic [31:0] ctrl_writedata = 32'd0;
    logic [31:0] ctrl_readdata;
    logic [7:0]  out_address = 8'd0;
    logic [31:0] out_readdata;
    logic        src_valid;
    logic        src_ready = 1'b1;
    logic [63:0] src_data;
    logic        snk_valid = 1'b0;
    logic        snk_ready;
    logic [63:0] snk_data = 64'd0;

    mmio_vector_bank dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .in_write(in_write), .in_address(in_address), .in_writedata(in_writedata),
        .ctrl_address(ctrl_address), .ctrl_read(ctrl_read), .ctrl_write(ctrl_write),
        .ctrl_writedata(ctrl_writedata), .ctrl_readdata(ctrl_readdata),
        .out_address(out_address), .out_readdata(out_readdata),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data)
    );

    always #5 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [31:0] in_model  [NCH][DEP];
    logic [31:0] out_model [NCH][DEP];
    logic [31:0] snap      [NCH][DEP];
    int          len_model = 0;

    // scoreboard queues
    logic [63:0] src_q[$];
    logic [31:0] ctrl_e[$];
    logic [31:0] ctrl_t[$];
    string       ctrl_n[$];
    logic [31:0] out_e[$];
    string       out_n[$];
    int          beat_cycles[$];
    logic        ctrl_rd_d = 1'b0;
    logic        out_rd_req = 1'b0;
    logic        out_rd_d = 1'b0;
    int          src_valid_seen = 0;
    int          mon_cyc = 0;

    // core model
    typedef struct { logic [63:0] data; int due; } res_t;
    res_t pend[$];
    int   core_cyc = 0;
    int   core_delay = 0;
    int   core_mode = 0;
    int   core_stop_at = -1;
    bit   core_flush = 1'b0;
    int   issue_m = 0;
    int   res_m = 0;

    task automatic check_tol(input string n, input logic [63:0] act, input logic [63:0] exp,
                             input logic [63:0] tol);
        n_checks++;
        if ((act + tol < exp) || (act > exp + tol)) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (tolerance %0d)", n, act, exp, tol);
        end
    endtask

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        check_tol(n, act, exp, 64'd0);
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic ctrl_wr(input logic [7:0] a, input logic [31:0] d);
        ctrl_address = a; ctrl_writedata = d; ctrl_write = 1'b1;
        tick();
        ctrl_write = 1'b0;
    endtask

    task automatic ctrl_rd_tol(input logic [7:0] a, input logic [31:0] e, input logic [31:0] t,
                               input string n);
        ctrl_e.push_back(e); ctrl_t.push_back(t); ctrl_n.push_back(n);
        ctrl_address = a; ctrl_read = 1'b1;
        tick();
        ctrl_read = 1'b0;
    endtask

    task automatic ctrl_rd(input logic [7:0] a, input logic [31:0] e, input string n);
        ctrl_rd_tol(a, e, 32'd0, n);
    endtask

    task automatic out_rd(input int ch, input int idx, input logic [31:0] e, input string n);
        out_e.push_back(e); out_n.push_back(n);
        out_address = {ch[0], idx[6:0]}; out_rd_req = 1'b1;
        tick();
        out_rd_req = 1'b0;
    endtask

    task automatic in_wr(input int ch, input int idx, input logic [31:0] d, input bit accepted);
        in_address = {ch[0], idx[6:0]}; in_writedata = d; in_write = 1'b1;
        if (accepted) in_model[ch][idx] = d;
        tick();
        in_write = 1'b0;
    endtask

    task automatic set_len(input int v);
        len_model = (v > DEP) ? DEP : v;
        ctrl_wr(8'd2, 32'(v));
    endtask

    task automatic start_run();
        for (int i = 0; i < len_model; i++) src_q.push_back({in_model[1][i], in_model[0][i]});
        issue_m = 0; res_m = 0;
        beat_cycles.delete();
        ctrl_wr(8'd0, 32'd1);
    endtask

    task automatic wait_res(input int target, input int budget, input string n);
        int k = 0;
        while (res_m < target && k < budget) begin
            tick();
            k++;
        end
        check(n, 64'(res_m), 64'(target));
    endtask

    task automatic load_random(input int cnt);
        for (int i = 0; i < cnt; i++)
            for (int c = 0; c < NCH; c++) in_wr(c, i, $urandom(), 1'b1);
    endtask

    task automatic check_out_echo(input int cnt, input string n);
        for (int i = 0; i < cnt; i++)
            for (int c = 0; c < NCH; c++) out_rd(c, i, in_model[c][i] + 32'd1, n);
    endtask

    // read-strobe pipeline matching the 1-cycle read latency
    always @(posedge clk_clk) begin
        ctrl_rd_d <= ctrl_read;
        out_rd_d  <= out_rd_req;
    end

    // monitor: pops expectations whenever the DUT presents an output
    initial begin : monitor
        logic [63:0] e64;
        forever begin
            @(negedge clk_clk);
            mon_cyc++;
            if (!reset_reset_n) continue;
            if (src_valid) src_valid_seen++;
            if (src_valid && src_ready) begin
                beat_cycles.push_back(mon_cyc);
                check("src_beat_expected", 64'(src_q.size() != 0), 64'd1);
                if (src_q.size() != 0) begin
                    e64 = src_q.pop_front();
                    check("src_data", src_data, e64);
                end
            end
            if (ctrl_rd_d && ctrl_e.size() != 0)
                check_tol(ctrl_n.pop_front(), 64'(ctrl_readdata), 64'(ctrl_e.pop_front()),
                          64'(ctrl_t.pop_front()));
            if (out_rd_d && out_e.size() != 0)
                check(out_n.pop_front(), 64'(out_readdata), 64'(out_e.pop_front()));
        end
    end

    // compute core model: echoes each issued vector +1 after core_delay cycles
    initial begin : core
        res_t r;
        forever begin
            @(negedge clk_clk);
            if (reset_reset_n) begin
                if (src_valid && src_ready) begin
                    for (int c = 0; c < NCH; c++) r.data[c*32 +: 32] = in_model[c][issue_m] + 32'd1;
                    r.due = core_cyc + core_delay;
                    pend.push_back(r);
                    issue_m++;
                end
                if (snk_valid && snk_ready) begin
                    for (int c = 0; c < NCH; c++) out_model[c][res_m] = snk_data[c*32 +: 32];
                    res_m++;
                    void'(pend.pop_front());
                end
            end
            @(posedge clk_clk);
            #1;
            core_cyc++;
            if (core_flush) begin
                pend.delete();
                core_flush = 1'b0;
            end
            if (pend.size() != 0 && pend[0].due <= core_cyc && res_m != core_stop_at) begin
                snk_valid = 1'b1; snk_data = pend[0].data;
            end else begin
                snk_valid = 1'b0; snk_data = 64'd0;
            end
            src_ready = (core_mode == 1) ? core_cyc[0] : 1'b1;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // reset state
        repeat (3) tick();
        check("rst_src_valid", 64'(src_valid), 64'd0);
        check("rst_snk_ready", 64'(snk_ready), 64'd0);
        reset_reset_n = 1'b1;
        tick();
        ctrl_rd(8'd1, 32'd0, "rst_status");
        ctrl_rd(8'd2, 32'd0, "rst_len");
        ctrl_rd(8'd3, 32'hA502_0080, "id");
        ctrl_rd(8'd0, 32'd0, "ctrl_reads_zero");
        ctrl_rd(8'd4, 32'd0, "rst_cycles");
        ctrl_rd(8'd9, 32'd0, "unmapped");

        // 1: basic echo run
        for (int i = 0; i < 4; i++) begin
            in_wr(0, i, 32'(i), 1'b1);
            in_wr(1, i, 32'(100 + i), 1'b1);
        end
        set_len(4);
        start_run();
        wait_res(4, 50, "t1_results");
        tick();
        ctrl_rd(8'd1, 32'd2, "t1_status_done");
        check("t1_src_all_issued", 64'(src_q.size()), 64'd0);
        check("t1_beats", 64'(beat_cycles.size()), 64'd4);
        if (beat_cycles.size() == 4)
            check("t1_beats_consecutive", 64'(beat_cycles[3] - beat_cycles[0]), 64'd3);
`ifdef MMIO_VECTOR_BANK_PERF_CNT_EN
        ctrl_rd_tol(8'd4, 32'd5, 32'd1, "t1_cycles");
`else
        ctrl_rd(8'd4, 32'd0, "t1_cycles_absent");
`endif
        for (int i = 0; i < 4; i++) begin
            out_rd(0, i, 32'(1 + i), "t1_out_ch0");
            out_rd(1, i, 32'(101 + i), "t1_out_ch1");
        end

        // 2: back-pressured issue, delayed results
        load_random(8);
        set_len(8);
        core_mode = 1; core_delay = 3;
        start_run();
        wait_res(7, 200, "t2_results7");
        ctrl_rd(8'd1, 32'd1, "t2_status_not_done");
        wait_res(8, 200, "t2_results8");
        tick();
        ctrl_rd(8'd1, 32'd2, "t2_status_done");
        check("t2_src_all_issued", 64'(src_q.size()), 64'd0);
        check("t2_beats", 64'(beat_cycles.size()), 64'd8);
        check_out_echo(8, "t2_out");

        // 3: illegal host activity while busy
        core_mode = 0; core_delay = 20;
        start_run();
        in_wr(0, 7, 32'hDEAD_BEEF, 1'b0);
        ctrl_wr(8'd0, 32'd1);
        set_len(3);
        ctrl_rd(8'd1, 32'd5, "t3_status_busy_err");
        wait_res(8, 300, "t3_results");
        tick();
        ctrl_rd(8'd1, 32'd6, "t3_status_done_err");
        ctrl_wr(8'd1, 32'd4);
        ctrl_rd(8'd1, 32'd2, "t3_err_cleared");
        ctrl_rd(8'd2, 32'd3, "t3_len_written_busy");
        check("t3_src_all_issued", 64'(src_q.size()), 64'd0);
        check_out_echo(8, "t3_out");

        // 4: zero length, LEN saturation, done W1C
        ctrl_wr(8'd1, 32'd2);
        ctrl_rd(8'd1, 32'd0, "t4_done_w1c");
        set_len(0);
        src_valid_seen = 0;
        start_run();
        tick();
        ctrl_rd(8'd1, 32'd2, "t4_status_done");
        repeat (3) tick();
        check("t4_no_src_valid", 64'(src_valid_seen), 64'd0);
        ctrl_wr(8'd2, 32'h0000_1000);
        ctrl_rd(8'd2, 32'd128, "t4_len_sat_big");
        ctrl_wr(8'd2, 32'd129);
        ctrl_rd(8'd2, 32'd128, "t4_len_sat_129");
        ctrl_wr(8'd2, 32'd128);
        ctrl_rd(8'd2, 32'd128, "t4_len_depth");

        // 5: abort after two results (start+abort in one write: abort wins)
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 6; i++) snap[c][i] = out_model[c][i];
        load_random(6);
        set_len(6);
        core_delay = 3; core_stop_at = 2;
        start_run();
        wait_res(2, 100, "t5_results2");
        repeat (2) tick();
        ctrl_wr(8'd0, 32'd3);
        ctrl_rd(8'd1, 32'd0, "t5_status_after_abort");
        check("t5_src_valid_dropped", 64'(src_valid), 64'd0);
        src_q.delete();
        core_flush = 1'b1; core_stop_at = -1;
        repeat (3) tick();
        check("t5_result_count", 64'(res_m), 64'd2);
        for (int i = 0; i < 6; i++)
            for (int c = 0; c < NCH; c++)
                out_rd(c, i, (i < 2) ? in_model[c][i] + 32'd1 : snap[c][i],
                       (i < 2) ? "t5_out_updated" : "t5_out_kept");

        // 6: asynchronous reset mid-run
        load_random(8);
        set_len(8);
        core_delay = 5;
        start_run();
        repeat (3) tick();
        reset_reset_n = 1'b0;
        #1;
        check("t6_src_valid_async", 64'(src_valid), 64'd0);
        check("t6_snk_ready_async", 64'(snk_ready), 64'd0);
        check("t6_readdata_async", 64'(ctrl_readdata), 64'd0);
        src_q.delete();
        core_flush = 1'b1;
        repeat (2) tick();
        reset_reset_n = 1'b1;
        len_model = 0;
        tick();
        ctrl_rd(8'd1, 32'd0, "t6_status_after_reset");
        ctrl_rd(8'd2, 32'd0, "t6_len_after_reset");
        load_random(4);
        set_len(4);
        core_delay = 1;
        start_run();
        wait_res(4, 100, "t6_results");
        tick();
        ctrl_rd(8'd1, 32'd2, "t6_status_done");
        check("t6_src_all_issued", 64'(src_q.size()), 64'd0);
        check_out_echo(4, "t6_out");

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
